mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch stage and its memory (load/store) stage.
- Replaces the separate instruction and data memories with one variable-latency port.
- Sequences one transaction at a time and returns per-requester done pulses and read data.
- Produces stall signals that the hazard unit ORs into the fetch and memory stall terms.

Parameters:
- TIMEOUT, 64, max cycles a granted transaction waits for mem_ready before abort; legal range 2..255.
- ADDR_W, 32, address width of both requesters and the memory port.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request; held high with i_addr stable until i_done or i_kill
- i_addr  in  ADDR_W  fetch address (pc)
- i_kill  in  1  cancel the current fetch (taken branch/jump redirect)
- i_done  out  1  one-cycle pulse, fetch data valid
- i_rdata  out  32  fetched instruction, valid when i_done=1
- d_req  in  1  data request; held with all d_* fields stable until d_done or d_err
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data
- d_funct3  in  3  access size/sign, passed through to memory
- d_done  out  1  one-cycle pulse, access complete
- d_rdata  out  32  load data, valid when d_done=1
- d_err  out  1  one-cycle pulse, data access timed out
- i_err  out  1  one-cycle pulse, fetch timed out
- stall_i  out  1  = i_req & ~i_done & ~i_kill
- stall_d  out  1  = d_req & ~d_done & ~d_err
- mem_valid  out  1  request to memory
- mem_we  out  1  write enable, 0 for fetches
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  write data, 0 for fetches
- mem_funct3  out  3  3'b010 for fetches, d_funct3 for data
- mem_ready  in  1  memory completes the current transaction this cycle
- mem_rdata  in  32  read data, valid with mem_ready

Behaviour:
- FSM states: IDLE, BUS_I, BUS_D.
- IDLE: mem_valid=0. If d_req=1, next state is BUS_D. Else if i_req=1 and i_kill=0, next state is BUS_I. A grant decision takes 1 cycle, so minimum latency from req to done is 2 cycles (mem_ready tied high).
- BUS_D: mem_valid=1; mem_we/mem_addr/mem_wdata/mem_funct3 driven combinationally from d_*.
  - On mem_ready: d_done=1 and d_rdata=mem_rdata in the same cycle; next state is IDLE.
- BUS_I: mem_valid=1, mem_we=0, mem_addr=i_addr, mem_wdata=0.
  - On mem_ready: i_done=1 and i_rdata=mem_rdata unless i_kill is high that cycle or was seen earlier in this transaction; next state is IDLE.
- i_kill in BUS_I:
  - Sets a kill_pending flag.
  - The transaction still runs until mem_ready, because memory accesses are not abortable; only i_done is suppressed.
  - kill_pending clears on leaving BUS_I.
- Back-to-back: IDLE is always visited between transactions. There is no same-cycle re-grant.
- Timeout:
  - An 8-bit wait counter clears on entry to BUS_I/BUS_D and increments each cycle mem_ready=0.
  - When the counter reaches TIMEOUT-1 with mem_ready=0, pulse d_err or i_err (i_err suppressed if killed), drop mem_valid and go to IDLE next cycle.
  - If mem_ready=1 in that same cycle, completion wins and there is no err.
- Requester dropping req while granted is illegal. The FSM finishes the transaction regardless and still pulses done.
- Reset: state=IDLE, counter=0, kill_pending=0, last_grant=0.
  - All outputs are 0: i_done, d_done, i_err, d_err, mem_valid, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, stall_i, stall_d.
  - mem_funct3 resets to 0.
  - Reset mid-transaction abandons it with no done/err pulse.
- i_rdata/d_rdata read 0 when their done is low.

Optional Feature:
- ARB_FAIR_EN defined:
  - A last_grant register records the side granted last (0=I, 1=D).
  - In IDLE with both requests pending, the side not granted last wins.
  - Bounds fetch starvation to one data transaction.
- ARB_FAIR_EN undefined: fixed priority, data always wins over fetch, no last_grant register.

Test Plan:
- mem_ready tied 1, i_req=1 addr 0x10, mem_rdata=0x00500093 -> mem_valid cycle 1, i_done + i_rdata=0x00500093 cycle 1, back in IDLE cycle 2.
- d_req store addr 0x100 wdata 0xDEADBEEF funct3 010, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles, d_done once, stall_d high until that cycle.
- i_req and d_req both high from reset release:
  - Without ARB_FAIR_EN: D served first, then I.
  - With ARB_FAIR_EN: D served, then I; a second simultaneous pair serves I first (last_grant=D).
- BUS_I at addr 0x20, i_kill pulsed 1 cycle before mem_ready -> mem_valid held to completion, no i_done, next fetch at 0x40 granted after IDLE.
- TIMEOUT=4, d_req load, mem_ready never -> d_err pulse on 4th BUS_D cycle, mem_valid low next cycle, no d_done.
- rst asserted in BUS_D after 2 wait cycles -> next cycle all outputs 0, no d_done; re-requests served normally after rst low.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch stage and the load/store stage.
// Optional build macro ARB_FAIR_EN: alternate grants when both sides request; otherwise data wins.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_kill,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              i_err,
    output logic              stall_i,
    output logic              stall_d,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUS_I,
        BUS_D
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       kill_pending_q, kill_pending_d;
    logic       i_eligible;
    logic       pick_d;
    logic       pick_i;
    logic       killed;

    // A fetch being cancelled this very cycle is not worth granting.
    assign i_eligible = i_req & ~i_kill;

`ifdef ARB_FAIR_EN
    logic last_grant_q, last_grant_d;

    // last_grant: 0 = fetch was served last, 1 = data was served last.
    assign pick_d = d_req & (~i_eligible | ~last_grant_q);
`else
    assign pick_d = d_req;
`endif
    assign pick_i = i_eligible & ~pick_d;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            kill_pending_q <= 1'b0;
`ifdef ARB_FAIR_EN
            last_grant_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            kill_pending_q <= kill_pending_d;
`ifdef ARB_FAIR_EN
            last_grant_q   <= last_grant_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        kill_pending_d = kill_pending_q;
`ifdef ARB_FAIR_EN
        last_grant_d   = last_grant_q;
`endif
        killed     = 1'b0;
        i_done     = 1'b0;
        i_rdata    = 32'd0;
        i_err      = 1'b0;
        d_done     = 1'b0;
        d_rdata    = 32'd0;
        d_err      = 1'b0;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        mem_funct3 = 3'b000;

        unique case (state_q)
            IDLE: begin
                cnt_d          = 8'd0;
                kill_pending_d = 1'b0;
                if (pick_d) begin
                    state_d = BUS_D;
`ifdef ARB_FAIR_EN
                    last_grant_d = 1'b1;
`endif
                end else if (pick_i) begin
                    state_d = BUS_I;
`ifdef ARB_FAIR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end

            BUS_I: begin
                mem_valid  = 1'b1;
                mem_addr   = i_addr;
                mem_funct3 = 3'b010;
                // The access cannot be aborted; a kill only silences the result.
                killed         = i_kill | kill_pending_q;
                kill_pending_d = killed;
                if (mem_ready) begin
                    i_done         = ~killed;
                    i_rdata        = killed ? 32'd0 : mem_rdata;
                    state_d        = IDLE;
                    kill_pending_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    i_err          = ~killed;
                    state_d        = IDLE;
                    kill_pending_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            BUS_D: begin
                mem_valid  = 1'b1;
                mem_we     = d_we;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                mem_funct3 = d_funct3;
                if (mem_ready) begin
                    d_done  = 1'b1;
                    d_rdata = mem_rdata;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    d_err   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        stall_i = i_req & ~i_done & ~i_kill;
        stall_d = d_req & ~d_done & ~d_err;

        // Reset silences every output, including one landing mid-transaction.
        if (rst) begin
            i_done     = 1'b0;
            i_rdata    = 32'd0;
            i_err      = 1'b0;
            d_done     = 1'b0;
            d_rdata    = 32'd0;
            d_err      = 1'b0;
            stall_i    = 1'b0;
            stall_d    = 1'b0;
            mem_valid  = 1'b0;
            mem_we     = 1'b0;
            mem_addr   = '0;
            mem_wdata  = 32'd0;
            mem_funct3 = 3'b000;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); inputs change 1 time unit after the
// rising edge and outputs are compared 2 time units later, mid-cycle.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_kill;
    logic              i_done;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [2:0]        d_funct3;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic              i_err;
    logic              stall_i;
    logic              stall_d;
    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        mem_funct3;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    bit first_is_i;

    mem_port_arbiter #(.TIMEOUT(4), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_kill     (i_kill),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_funct3   (d_funct3),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .i_err      (i_err),
        .stall_i    (stall_i),
        .stall_d    (stall_d),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_funct3 (mem_funct3),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs be changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the directed sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; i_kill = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        d_funct3 = 3'b010; mem_ready = 1'b1; mem_rdata = 32'h12345678;
        cyc(); cyc();
        settle();
        check("rst_mem_valid", mem_valid, 0);
        check("rst_stall_i", stall_i, 0);
        check("rst_stall_d", stall_d, 0);
        check("rst_mem_funct3", mem_funct3, 0);
        check("rst_mem_addr", mem_addr, 0);

        // Fetch with an always-ready memory.
        i_req = 1'b0; d_req = 1'b0; mem_rdata = 32'h00500093;
        cyc();
        rst = 1'b0; i_req = 1'b1;
        settle();
        check("f_c0_valid", mem_valid, 0);
        check("f_c0_stall_i", stall_i, 1);
        cyc(); settle();
        check("f_c1_valid", mem_valid, 1);
        check("f_c1_addr", mem_addr, 32'h10);
        check("f_c1_we", mem_we, 0);
        check("f_c1_funct3", mem_funct3, 3'b010);
        check("f_c1_wdata", mem_wdata, 0);
        check("f_c1_done", i_done, 1);
        check("f_c1_rdata", i_rdata, 32'h00500093);
        check("f_c1_stall_i", stall_i, 0);
        cyc();
        i_req = 1'b0;
        settle();
        check("f_c2_valid", mem_valid, 0);
        check("f_c2_done", i_done, 0);
        check("f_c2_rdata", i_rdata, 0);

        // Store that completes exactly on the last cycle before timeout.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        d_funct3 = 3'b010; mem_ready = 1'b0;
        settle();
        check("s_c0_we", mem_we, 0);
        check("s_c0_stall_d", stall_d, 1);
        for (int k = 1; k <= 3; k++) begin
            cyc(); settle();
            check($sformatf("s_c%0d_we", k), mem_we, 1);
            check($sformatf("s_c%0d_wdata", k), mem_wdata, 32'hDEADBEEF);
            check($sformatf("s_c%0d_addr", k), mem_addr, 32'h100);
            check($sformatf("s_c%0d_done", k), d_done, 0);
            check($sformatf("s_c%0d_err", k), d_err, 0);
            check($sformatf("s_c%0d_stall_d", k), stall_d, 1);
        end
        cyc();
        mem_ready = 1'b1;
        settle();
        check("s_c4_we", mem_we, 1);
        check("s_c4_done", d_done, 1);
        check("s_c4_err", d_err, 0);
        check("s_c4_stall_d", stall_d, 0);
        cyc();
        d_req = 1'b0; mem_ready = 1'b0;
        settle();
        check("s_c5_valid", mem_valid, 0);
        check("s_c5_done", d_done, 0);

        // Both sides requesting straight out of reset.
        rst = 1'b1;
        cyc();
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h200; d_funct3 = 3'b000; mem_ready = 1'b1; mem_rdata = 32'h11111111;
        settle();
        check("b_c0_stall_i", stall_i, 1);
        check("b_c0_stall_d", stall_d, 1);
        cyc(); settle();
        check("b_c1_addr", mem_addr, 32'h200);
        check("b_c1_we", mem_we, 0);
        check("b_c1_d_done", d_done, 1);
        check("b_c1_d_rdata", d_rdata, 32'h11111111);
        check("b_c1_i_done", i_done, 0);
        check("b_c1_stall_i", stall_i, 1);
        // Issue a follow-on load right after completion while the fetch still waits.
        cyc();
        d_addr = 32'h204; mem_rdata = 32'h22222222;
        settle();
        check("b_c2_valid", mem_valid, 0);
`ifdef ARB_FAIR_EN
        first_is_i = 1'b1;
`else
        first_is_i = 1'b0;
`endif
        cyc(); settle();
        check("b_c3_addr", mem_addr, first_is_i ? 32'h30 : 32'h204);
        check("b_c3_i_done", i_done, {31'd0, first_is_i});
        check("b_c3_d_done", d_done, {31'd0, ~first_is_i});
        cyc();
        if (first_is_i) i_req = 1'b0; else d_req = 1'b0;
        settle();
        check("b_c4_valid", mem_valid, 0);
        cyc(); settle();
        check("b_c5_addr", mem_addr, first_is_i ? 32'h204 : 32'h30);
        check("b_c5_i_done", i_done, {31'd0, ~first_is_i});
        check("b_c5_d_done", d_done, {31'd0, first_is_i});
        cyc();
        i_req = 1'b0; d_req = 1'b0;
        settle();
        check("b_c6_valid", mem_valid, 0);

        // Fetch killed one cycle before the memory answers.
        i_req = 1'b1; i_addr = 32'h20; mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
        cyc(); settle();
        check("k_c1_valid", mem_valid, 1);
        check("k_c1_addr", mem_addr, 32'h20);
        cyc();
        i_kill = 1'b1;
        settle();
        check("k_c2_valid", mem_valid, 1);
        check("k_c2_stall_i", stall_i, 0);
        check("k_c2_done", i_done, 0);
        cyc();
        i_kill = 1'b0; mem_ready = 1'b1;
        settle();
        check("k_c3_valid", mem_valid, 1);
        check("k_c3_done", i_done, 0);
        check("k_c3_rdata", i_rdata, 0);
        check("k_c3_err", i_err, 0);
        cyc();
        i_addr = 32'h40; mem_rdata = 32'h00000013;
        settle();
        check("k_c4_valid", mem_valid, 0);
        cyc(); settle();
        check("k_c5_addr", mem_addr, 32'h40);
        check("k_c5_done", i_done, 1);
        check("k_c5_rdata", i_rdata, 32'h00000013);
        cyc();
        i_req = 1'b0; mem_ready = 1'b0;

        // Load that never gets an answer.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'b100;
        for (int k = 1; k <= 3; k++) begin
            cyc(); settle();
            check($sformatf("t_c%0d_err", k), d_err, 0);
            check($sformatf("t_c%0d_valid", k), mem_valid, 1);
        end
        cyc(); settle();
        check("t_c4_err", d_err, 1);
        check("t_c4_done", d_done, 0);
        check("t_c4_stall_d", stall_d, 0);
        check("t_c4_funct3", mem_funct3, 3'b100);
        cyc();
        d_req = 1'b0;
        settle();
        check("t_c5_valid", mem_valid, 0);
        check("t_c5_err", d_err, 0);

        // Reset landing in the middle of a store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'hA5A5A5A5; d_funct3 = 3'b010;
        cyc(); cyc(); cyc();
        rst = 1'b1; mem_ready = 1'b1;
        settle();
        check("r_c3_done", d_done, 0);
        check("r_c3_valid", mem_valid, 0);
        cyc(); settle();
        check("r_c4_valid", mem_valid, 0);
        check("r_c4_we", mem_we, 0);
        check("r_c4_wdata", mem_wdata, 0);
        check("r_c4_done", d_done, 0);
        check("r_c4_stall_d", stall_d, 0);
        cyc();
        rst = 1'b0; mem_rdata = 32'h0BADC0DE;
        settle();
        check("r_c5_valid", mem_valid, 0);
        check("r_c5_stall_d", stall_d, 1);
        cyc(); settle();
        check("r_c6_addr", mem_addr, 32'h400);
        check("r_c6_we", mem_we, 1);
        check("r_c6_done", d_done, 1);
        cyc();
        d_req = 1'b0;
        settle();
        check("r_c7_valid", mem_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
